fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Fetch stage of the multicycle MIPS datapath; sits directly upstream of the instruction decode/control block.
//   Owns the PC and the instruction register (IR) and runs a req/ack handshake with instruction memory.
//   Splits the IR into the fields the decoder consumes (opcode, functionCode, rs, rt, rd, shamt, imm, jump target).
//   Pulses instr_valid once per completed fetch.
// PARAMETERS
//   RESET_PC        32'h0000_0000  PC value loaded on reset
//   PC_INC          4              byte increment applied after each successful fetch
//   TIMEOUT_CYCLES  16             max REQ cycles before abort (used only with FETCH_TIMEOUT_EN)
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-high reset
//   fetch_start    in   1   request one instruction fetch from address pc
//   pc_load        in   1   redirect PC (branch/jump resolved by control)
//   pc_next        in   32  redirect target; bits [1:0] forced to 0 on load
//   mem_req        out  1   memory read request, held until ack
//   mem_addr       out  32  read address (= pc while mem_req=1)
//   mem_rdata      in   32  instruction word, valid in the mem_ack cycle
//   mem_ack        in   1   one-cycle acknowledge from memory
//   pc             out  32  current PC
//   instr          out  32  IR contents
//   opcode         out  6   instr[31:26]
//   functionCode   out  6   instr[5:0]
//   rs, rt, rd     out  5   instr[25:21], [20:16], [15:11]
//   shamt          out  5   instr[10:6]
//   imm_sext       out  32  sign-extended instr[15:0]
//   jump_addr      out  26  instr[25:0]
//   instr_valid    out  1   one-cycle pulse: IR updated, fields stable
//   busy           out  1   1 while state==REQ
//   fetch_err      out  1   sticky timeout flag (0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, IR=0, state=IDLE; mem_req, instr_valid, busy, fetch_err, pend_valid all 0.
//   FSM states: IDLE, REQ, DONE.
//     IDLE: fetch_start -> REQ.
//     REQ: mem_req=1, mem_addr=pc. On mem_ack -> IR<=mem_rdata, then DONE.
//       PC update on the ack edge: pc<=pend_valid ? pend_pc : pc+PC_INC (32-bit wrap, 0xFFFF_FFFC+4=0).
//     DONE: instr_valid=1 for this cycle only. fetch_start -> REQ (back-to-back), else -> IDLE.
//   Latency: fetch_start at edge N -> mem_req from N+1 -> ack at edge M -> instr_valid during cycle M+1.
//   pc_load in IDLE/DONE: pc<=pc_next&~3 on the same edge.
//     With simultaneous fetch_start, the fetch uses the new PC.
//   pc_load in REQ: deferred into pend_pc/pend_valid and applied at ack instead of pc+PC_INC.
//     A later load overwrites the pending value. pend_valid clears at ack.
//   mem_ack outside REQ: ignored. mem_rdata is sampled only in the ack cycle.
//   IR and the decoded fields hold their values between fetches. The fields are combinational from IR.
//   Reset mid-REQ: mem_req drops immediately; the pending load and the in-flight fetch are discarded.
// CONFIGURATION
//   FETCH_TIMEOUT_EN defined:
//     A counter runs in REQ, cleared on REQ entry.
//     If it reaches TIMEOUT_CYCLES with no ack: mem_req drops, state -> IDLE, fetch_err<=1 (sticky until reset).
//     IR and PC are unchanged; a pending load is dropped; no instr_valid pulse.
//   FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_err tied 0.
// STRUCTURE
//   Shared include fetch_defs.vh:
//     FSM state encodings (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
//     IR field bit positions.
//     Opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010.
//   One combinational sub-module ir_field_split: IR -> opcode/functionCode/rs/rt/rd/shamt/imm_sext/jump_addr.
// TESTING
//   1. Reset, fetch_start, ack after 2 cycles with mem_rdata=32'h8C22_0004.
//      -> mem_addr=0; opcode=6'b100011, rt=2, imm_sext=4; pc=4; one instr_valid pulse.
//   2. Back-to-back: fetch_start held in DONE, ack each after 0 wait.
//      -> mem_addr 0,4,8; three instr_valid pulses, no IDLE gap.
//   3. pc_load pc_next=32'h0000_0103 during REQ, then ack.
//      -> pc=32'h0000_0100 (not pc+4); next mem_addr=0x100.
//   4. pc=32'hFFFF_FFFC, fetch, ack -> pc wraps to 0. A stray mem_ack in IDLE -> IR unchanged.
//   5. Assert reset mid-REQ -> mem_req=0 same cycle; pc=RESET_PC; no instr_valid.
//   6. FETCH_TIMEOUT_EN, no ack for 16 cycles -> mem_req drops, fetch_err=1 sticky, pc unchanged.
//      Without the macro, mem_req stays high.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch definitions: FSM states, IR field positions, opcodes
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // IR field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SH_MSB    = 10;
    localparam int SH_LSB    = 6;
    localparam int FN_MSB    = 5;
    localparam int FN_LSB    = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JMP_MSB   = 25;
    localparam int JMP_LSB   = 0;

    // Opcodes the decoder cares about
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/fetch_unit_ir_field_split.sv
// rtl/fetch_unit_ir_field_split.sv - combinational split of the IR into decoder fields
module ir_field_split
    import fetch_unit_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [5:0]  opcode_o,
    output logic [5:0]  function_code_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [31:0] imm_sext_o,
    output logic [25:0] jump_addr_o
);

    // Pure wiring plus sign extension of the 16-bit immediate
    always_comb begin
        opcode_o        = ir_i[OP_MSB:OP_LSB];
        function_code_o = ir_i[FN_MSB:FN_LSB];
        rs_o            = ir_i[RS_MSB:RS_LSB];
        rt_o            = ir_i[RT_MSB:RT_LSB];
        rd_o            = ir_i[RD_MSB:RD_LSB];
        shamt_o         = ir_i[SH_MSB:SH_LSB];
        imm_sext_o      = {{16{ir_i[IMM_MSB]}}, ir_i[IMM_MSB:IMM_LSB]};
        jump_addr_o     = ir_i[JMP_MSB:JMP_LSB];
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS multicycle fetch stage (PC, IR, mem req/ack); optional FETCH_TIMEOUT_EN
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_INC         = 32'd4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  functionCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [31:0] imm_sext,
    output logic [25:0] jump_addr,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  load_pc;

    assign load_pc = pc_next & ~32'd3;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Timeout counter and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // FSM state, PC, IR and deferred-redirect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Next-state logic: redirects apply at once outside REQ, and are parked until ack inside it
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d        = '0;
        err_d        = err_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (mem_ack) begin
                    ir_d         = mem_rdata;
                    // A load arriving on the ack edge is the most recent redirect
                    if (pc_load)
                        pc_d = load_pc;
                    else if (pend_valid_q)
                        pc_d = pend_pc_q;
                    else
                        pc_d = pc_q + PC_INC;
                    pend_valid_d = 1'b0;
                    state_d      = ST_DONE;
                end else begin
                    if (pc_load) begin
                        pend_pc_d    = load_pc;
                        pend_valid_d = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d      = ST_IDLE;
                        pend_valid_d = 1'b0;
                        err_d        = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            ST_IDLE, ST_DONE: begin
                if (pc_load)
                    pc_d = load_pc;
                state_d = fetch_start ? ST_REQ : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req     = (state_q == ST_REQ);
    assign busy        = (state_q == ST_REQ);
    assign instr_valid = (state_q == ST_DONE);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;

    ir_field_split u_split (
        .ir_i            (ir_q),
        .opcode_o        (opcode),
        .function_code_o (functionCode),
        .rs_o            (rs),
        .rt_o            (rt),
        .rd_o            (rd),
        .shamt_o         (shamt),
        .imm_sext_o      (imm_sext),
        .jump_addr_o     (jump_addr)
    );

endmodule
